// File: rtl/inst_fetch_queue_if.sv
// Bundle of the fetch stage's control, memory read port and decode-side signals.
//
// Handshakes:
//   memory : mem_en/mem_addr form a request that stays asserted and stable until
//            the cycle mem_valid is sampled high; mem_valid with mem_rdata is the
//            single-cycle response. One request is outstanding at a time.
//   decode : inst_valid is "valid", ~stall_global is "ready"; the head entry
//            transfers on any clock edge where both are high, and inst/inst_pc
//            stay stable while valid is high and ready is low.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
);
  logic                         ce;
  logic                         stall_global;
  logic                         redirect_valid;
  logic [ADDR_W-1:0]            redirect_pc;
  logic                         mem_en;
  logic [ADDR_W-1:0]            mem_addr;
  logic                         mem_valid;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         inst_valid;
  logic [INST_W-1:0]            inst;
  logic [ADDR_W-1:0]            inst_pc;
  logic                         stall_from_inst_if;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  // Fetch stage side.
  modport master (
    input  ce, stall_global, redirect_valid, redirect_pc, mem_valid, mem_rdata,
    output mem_en, mem_addr, inst_valid, inst, inst_pc, stall_from_inst_if, occupancy
  );

  // Environment side (PC/branch logic, memory, decode).
  modport slave (
    output ce, stall_global, redirect_valid, redirect_pc, mem_valid, mem_rdata,
    input  mem_en, mem_addr, inst_valid, inst, inst_pc, stall_from_inst_if, occupancy
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues sequential reads, buffers returned
// instructions with their PCs in a DEPTH-entry FIFO, and presents the head to
// decode. Redirect flushes the FIFO and drains any read still in flight.
module inst_fetch_queue #(
  parameter int          ADDR_W   = 64,
  parameter int          INST_W   = 32,
  parameter int          DATA_W   = 64,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  inst_fetch_queue_if.master   bus,
  output logic [1:0]           state_dbg
);

  localparam int OFF_W = $clog2(INST_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((INST_W / 8) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic              mem_en_q, mem_en_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              push, pop, inst_valid;
  logic [INST_W-1:0] lane;
  logic [ADDR_W-1:0] redir_pc;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  // FIFO control and fetch FSM next-state; redirect overrides issue, push and pop.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_en_n   = mem_en_q;
    mem_addr_n = mem_addr_q;
    redir_pc   = bus.redirect_pc & ALIGN_MASK;
    lane       = bus.mem_rdata[INST_W-1:0];
    if (DATA_W == 2 * INST_W) begin
      lane = fetch_pc[OFF_W] ? bus.mem_rdata[DATA_W-1 -: INST_W] : bus.mem_rdata[INST_W-1:0];
    end
    pop        = inst_valid && !bus.stall_global && !bus.redirect_valid;
    push       = (state == S_WAIT) && bus.mem_valid && !bus.redirect_valid;
    count_next = count + CNT_W'(push) - CNT_W'(pop);

    case (state)
      S_IDLE: begin
        if (bus.redirect_valid) begin
          fetch_pc_n = redir_pc;
        end else if (bus.ce && (count < CNT_W'(DEPTH))) begin
          // Reserving the slot here is what keeps a later push from overflowing.
          mem_en_n   = 1'b1;
          mem_addr_n = fetch_pc;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          fetch_pc_n = redir_pc;
          if (bus.mem_valid) begin
            mem_en_n = 1'b0;
            state_n  = S_IDLE;
          end else begin
            state_n  = S_DRAIN;
          end
        end else if (bus.mem_valid) begin
          fetch_pc_n = fetch_pc + PC_INC;
          if (bus.ce && (count_next < CNT_W'(DEPTH))) begin
            mem_addr_n = fetch_pc + PC_INC;
          end else begin
            mem_en_n = 1'b0;
            state_n  = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // The stale read must still complete; its data is dropped.
        if (bus.redirect_valid) begin
          fetch_pc_n = redir_pc;
        end
        if (bus.mem_valid) begin
          mem_en_n = 1'b0;
          state_n  = S_IDLE;
        end
      end
      default: begin
        state_n  = S_IDLE;
        mem_en_n = 1'b0;
      end
    endcase
  end

  // State, request, pointer and count registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= S_IDLE;
      fetch_pc   <= ADDR_W'(RESET_PC);
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      mem_en_q   <= mem_en_n;
      mem_addr_q <= mem_addr_n;
      if (bus.redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_next;
      end
    end
  end

  // FIFO storage write; contents are qualified by count so need no reset.
  always_ff @(posedge ACLK) begin
    if (push) begin
      inst_mem[wr_ptr] <= lane;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  assign inst_valid             = (count != '0);
  assign bus.inst_valid         = inst_valid;
  assign bus.inst               = inst_valid ? inst_mem[rd_ptr] : '0;
  assign bus.inst_pc            = inst_valid ? pc_mem[rd_ptr] : '0;
  assign bus.mem_en             = mem_en_q;
  assign bus.mem_addr           = mem_addr_q;
  assign bus.occupancy          = count;
  assign bus.stall_from_inst_if = bus.ce & ~inst_valid & ~ARESET;
  assign state_dbg              = state;

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised next-generation instruction fetch stage, sitting between the PC/branch logic and decode.
- Issues sequential fetches to the memory read port and buffers returned instructions, with their PCs, in a DEPTH-entry FIFO.
- Presents the FIFO head to decode, holding it stable under stall_global.
- Supports redirect/flush, including discarding a fetch still in flight.

Parameters:
ADDR_W, 64, fetch address / PC width
INST_W, 32, instruction width; PC increment = INST_W/8
DATA_W, 64, memory read data width; must be INST_W or 2*INST_W
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 64'h8000_0000, fetch PC after reset

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
ce  in  1  fetch enable; low = issue no new requests
stall_global  in  1  decode not accepting; head entry held
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch PC; low log2(INST_W/8) bits forced to zero
mem_en  out  1  read request, held high until mem_valid
mem_addr  out  ADDR_W  read address, stable while mem_en high
mem_valid  in  1  read data valid; honoured only in WAIT/DRAIN
mem_rdata  in  DATA_W  read data
inst_valid  out  1  FIFO non-empty
inst  out  INST_W  head instruction
inst_pc  out  ADDR_W  head PC
stall_from_inst_if  out  1  = ce & ~inst_valid
occupancy  out  $clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE; mem_en=0; mem_addr=0; occupancy=0.
  - inst_valid=0, inst=0, inst_pc=0; stall_from_inst_if forced 0 while ARESET high.
- Reset mid-fetch abandons the request. A mem_valid arriving afterwards in IDLE is ignored.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - If ce & ~redirect_valid & occupancy<DEPTH: register mem_en=1, mem_addr=fetch_pc; go to WAIT.
  - Request is visible the cycle after the decision.
- WAIT, on mem_valid:
  - Push {fetch_pc, lane}; fetch_pc += INST_W/8.
  - If ce & next occupancy<DEPTH: stay in WAIT with new mem_addr next cycle (back-to-back, 1 instr per 2 cycles minimum). Else mem_en=0, go to IDLE.
- WAIT, no mem_valid: hold mem_en and mem_addr. ce dropping does not cancel an outstanding request.
- Lane select:
  - DATA_W==2*INST_W: lane = fetch_pc[log2(INST_W/8)] ? upper half : lower half.
  - DATA_W==INST_W: lane = mem_rdata.
- Only one request is outstanding at a time. A slot is reserved at issue, so push never overflows.
- Pop: inst_valid & ~stall_global pops the head at the clock edge. inst/inst_pc are combinational from the head entry, so they are stable while stall_global is high.
- Simultaneous push and pop: occupancy unchanged; new entry goes to the tail. At full, a push cannot occur because no request was issued.
- Redirect has priority over issue, push and pop:
  - FIFO cleared (occupancy=0 next cycle); fetch_pc=redirect_pc.
  - In WAIT without mem_valid: go to DRAIN, keeping mem_en/mem_addr until mem_valid, then discard the data and go to IDLE.
  - In WAIT with mem_valid the same cycle: discard the data, go to IDLE.
  - In DRAIN: update fetch_pc only.
  - No new request issues in the redirect cycle.
- Pointers wrap modulo DEPTH; occupancy saturates at DEPTH by construction.
- FIFO storage needs no reset; only pointers/count are reset.

Test Plan:
- Reset release, ce=1, memory returns mem_valid 2 cycles after mem_en -> mem_addr=0x8000_0000 then 0x8000_0004. inst_valid rises the cycle after the first mem_valid, with inst_pc=0x8000_0000 and inst = lower 32 bits of rdata; the second returns the upper 32 bits.
- stall_global=1 for 10 cycles, memory 1-cycle latency, DEPTH=4 -> exactly 4 pushes, occupancy=4, mem_en low, head inst/inst_pc unchanged. Releasing the stall pops 1 per cycle and fetch resumes.
- Redirect to 0x8000_0100 while in WAIT with mem_valid delayed 3 cycles -> FIFO empties next cycle; mem_addr held until mem_valid; that data is discarded. Next request is 0x8000_0100, and the first popped inst_pc is 0x8000_0100.
- Redirect in the same cycle as mem_valid and a pop -> no push, occupancy=0 next cycle, FSM IDLE, next mem_addr = redirect_pc.
- ce=0 with empty FIFO -> stall_from_inst_if=0 and no mem_en. ce=1 and empty -> stall_from_inst_if=1 until the first push.
- ARESET pulsed mid-WAIT -> all outputs return to reset values immediately. A stray mem_valid after release is ignored, and the first fetch restarts at 0x8000_0000.
